// File: rtl/iterative_comparator.sv
// Multi-cycle signed/unsigned/equality comparator, CHUNK bits per cycle from the MSB, with a start/done handshake.
// Optional macro COMPARATOR_EARLY_TERM_EN stops on the first differing chunk; otherwise always runs BITS/CHUNK cycles.
module iterative_comparator #(
  parameter int BITS  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            LT,
  output logic            LTU,
  output logic            EQ
);

  localparam int NCHUNK = BITS / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NCHUNK - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t          r_state;
  logic [BITS-1:0] r_a;
  logic [BITS-1:0] r_b;
  logic [IW-1:0]   r_idx;
  logic            r_sign_a;
  logic            r_sign_b;
  logic            r_found;
  logic            r_cltu;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_lt;
  logic            r_ltu;
  logic            r_eq;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic             w_differ;
  logic             w_found_final;
  logic             w_cltu_final;
  logic             w_ltu_final;
  logic             w_term;

  // Operands shift left each busy cycle, so the chunk under test is always the top one.
  assign w_a_chunk     = r_a[BITS-1 -: CHUNK];
  assign w_b_chunk     = r_b[BITS-1 -: CHUNK];
  assign w_differ      = (w_a_chunk != w_b_chunk);
  assign w_found_final = r_found | w_differ;
  assign w_cltu_final  = r_found ? r_cltu : (w_a_chunk < w_b_chunk);
  assign w_ltu_final   = w_found_final & w_cltu_final;

`ifdef COMPARATOR_EARLY_TERM_EN
  assign w_term = w_found_final | (r_idx == '0);
`else
  assign w_term = (r_idx == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_found  <= 1'b0;
      r_cltu   <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_lt     <= 1'b0;
      r_ltu    <= 1'b0;
      r_eq     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_sign_a <= A[BITS-1];
            r_sign_b <= B[BITS-1];
            r_idx    <= IDX_LAST;
            r_found  <= 1'b0;
            r_cltu   <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Only the first (most significant) difference decides the ordering.
          if (!r_found && w_differ) begin
            r_found <= 1'b1;
            r_cltu  <= w_a_chunk < w_b_chunk;
          end
          if (w_term) begin
            r_eq    <= ~w_found_final;
            r_ltu   <= w_ltu_final;
            r_lt    <= (r_sign_a != r_sign_b) ? r_sign_a : w_ltu_final;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx - IDX_ONE;
            r_a   <= r_a << CHUNK;
            r_b   <= r_b << CHUNK;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign LT    = r_lt;
  assign LTU   = r_ltu;
  assign EQ    = r_eq;

endmodule

// File: tb/tb_iterative_comparator.sv
// Self-checking bench for iterative_comparator (BITS=32, CHUNK=8): vector table, random ops and handshake corner cases.
module tb_iterative_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready, busy, done, lt, ltu, eq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        lt;
    logic        ltu;
    logic        eq;
    int          k;
  } vec_t;

  typedef struct {
    logic lt;
    logic ltu;
    logic eq;
    int   k;
    int   acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[15];

  iterative_comparator #(.BITS(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
    .ready(ready), .busy(busy), .done(done), .LT(lt), .LTU(ltu), .EQ(eq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int model_k(input logic [31:0] x, input logic [31:0] y);
`ifdef COMPARATOR_EARLY_TERM_EN
    for (int i = 3; i >= 0; i--)
      if (x[i*8 +: 8] != y[i*8 +: 8]) return 4 - i;
`endif
    return 4;
  endfunction

  function automatic int table_k(input int k_early);
`ifdef COMPARATOR_EARLY_TERM_EN
    return k_early;
`else
    return (k_early > 0) ? 4 : 4;
`endif
  endfunction

  // Waits for ready, drives one start pulse, and optionally queues the expected result.
  task automatic start_op(input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic e_lt, input logic e_ltu, input logic e_eq,
                          input int e_k, input bit expect_done);
    int guard = 0;
    exp_t e;
    @(negedge clk);
    while (!ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
    a = a_i;
    b = b_i;
    start = 1'b1;
    if (expect_done) begin
      e.lt = e_lt; e.ltu = e_ltu; e.eq = e_eq; e.k = e_k; e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("flags_lt_ltu_eq", {61'd0, lt, ltu, eq}, {61'd0, mon_e.lt, mon_e.ltu, mon_e.eq});
        chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.k));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int guard;
    logic [31:0] ra, rb, mask;

    tbl[0]  = '{32'h12345678, 32'h12345679, 1'b1, 1'b1, 1'b0, 4};
    tbl[1]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 1};
    tbl[2]  = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 4};
    tbl[3]  = '{32'h00000005, 32'h00000003, 1'b0, 1'b0, 1'b0, 4};
    tbl[4]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1};
    tbl[5]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1};
    tbl[6]  = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0, 1};
    tbl[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 4};
    tbl[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 4};
    tbl[9]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 4};
    tbl[10] = '{32'h12AB0000, 32'h12CD0000, 1'b1, 1'b1, 1'b0, 2};
    tbl[11] = '{32'h0000FF00, 32'h00000F00, 1'b0, 1'b0, 1'b0, 3};
    tbl[12] = '{32'h00FF0001, 32'h00FF0000, 1'b0, 1'b0, 1'b0, 4};
    tbl[13] = '{32'h01000000, 32'h00FFFFFF, 1'b0, 1'b0, 1'b0, 1};
    tbl[14] = '{32'hFF000000, 32'hFF000001, 1'b1, 1'b1, 1'b0, 4};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {58'd0, ready, busy, done, lt, ltu, eq}, {58'd0, 6'b100000});
    @(posedge clk);
    #1 rst = 1'b0;

    // Busy/ready window of the first test-plan operation.
    start_op(32'h12345678, 32'h12345679, 1'b1, 1'b1, 1'b0, 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_window", {62'd0, ready, busy}, {62'd0, 2'b01});
    end
    @(negedge clk);
    chk("ready_in_done_cycle", {61'd0, ready, busy, done}, {61'd0, 3'b101});

    // Table vectors, issued back to back (each start lands in the previous done cycle).
    for (int i = 0; i < 15; i++)
      start_op(tbl[i].a, tbl[i].b, tbl[i].lt, tbl[i].ltu, tbl[i].eq, table_k(tbl[i].k), 1'b1);

    // Random operands sharing a prefix so differences fall on assorted chunks.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      mask = 32'hFF << (8 * $urandom_range(0, 3));
      rb = ($urandom_range(0, 4) == 0) ? ra : (ra ^ ($urandom & mask));
      start_op(ra, rb, $signed(ra) < $signed(rb), ra < rb, ra == rb, model_k(ra, rb), 1'b1);
    end

    // Flags hold while the next operation is busy.
    start_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 4, 1'b1);
    start_op(32'h00000005, 32'h00000003, 1'b0, 1'b0, 1'b0, 4, 1'b1);
    @(negedge clk);
    chk("flags_hold_while_busy", {60'd0, busy, lt, ltu, eq}, {60'd0, 4'b1001});

    // Start pulsed while busy is ignored.
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    dc = done_cnt;
    start_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, model_k(32'h7FFFFFFF, 32'hFFFFFFFF), 1'b1);
    @(negedge clk);
    a = 32'h0;
    b = 32'h1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    chk("single_done_for_ignored_start", 64'(done_cnt - dc), 64'd1);
    chk("idle_after_ignored_start", {62'd0, ready, busy}, {62'd0, 2'b10});

    // Reset in the second busy cycle aborts with no done pulse.
    dc = done_cnt;
    start_op(32'h00000001, 32'h00000002, 1'b1, 1'b1, 1'b0, 4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {58'd0, ready, busy, done, lt, ltu, eq}, {58'd0, 6'b100000});
    repeat (6) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - dc), 64'd0);

    // Drain: every queued operation must have completed.
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
